// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Sequences the reset of a PLL and of the logic downstream of it. The PLL is
// held in reset for RST_CYCLES clocks. The controller then waits up to
// LOCK_TIMEOUT clocks for lock, and pulses the PLL reset again if lock does
// not arrive. Lock must then be held for STABLE_CYCLES consecutive clocks
// before the downstream reset is released. Any later loss of lock sends the
// controller back to the PLL reset pulse.
//
// Everything runs on clk, which is the PLL reference clock. That clock keeps
// running while the PLL is unlocked.
//
// Ports
//   clk          in   1  free-running reference clock (also the PLL CLKIN)
//   reset        in   1  asynchronous, active-high reset
//   pll_locked   in   1  PLL LOCKED output, asynchronous to clk
//   pll_rst      out  1  PLL RST input, active-high, straight from a flop
//   sys_reset    out  1  downstream reset, active-high, straight from a flop
//   retry_count  out  4  PLL re-resets since reset, saturating at 15
//   state        out  2  0=S_PLLRST 1=S_WAITLOCK 2=S_STABLE 3=S_RUN
//
// Parameters
//   RST_CYCLES     clocks pll_rst is held high per pulse (>=1)
//   LOCK_TIMEOUT   clocks to wait for lock before re-pulsing pll_rst (>=2)
//   STABLE_CYCLES  consecutive locked clocks before sys_reset releases (>=1)
// -----------------------------------------------------------------------------
module pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic [3:0] retry_count,
  output logic [1:0] state
);

  // Largest of three integers; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Saturating increment for the 4-bit retry counter; sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'd15) begin
      r = 4'd15;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  // The counter only has to reach (longest interval - 1).
  localparam int MAX_CYC = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLLRST   = 2'd0,
    S_WAITLOCK = 2'd1,
    S_STABLE   = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  // Registers
  logic             locked_meta_r;
  logic             locked_sync_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       retry_r;
  logic             pll_rst_r;
  logic             sys_reset_r;

  // Next-state signals
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             retry_inc_s;

  // Two-flop synchronizer for the asynchronous LOCKED input. The first flop
  // may go metastable; only the second flop feeds the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_meta_r <= 1'b0;
      locked_sync_r <= 1'b0;
    end else begin
      locked_meta_r <= pll_locked;
      locked_sync_r <= locked_meta_r;
    end
  end

  // FSM next-state and counter logic. The counter clears on every transition.
  // In S_WAITLOCK a lock that arrives on the timeout edge wins over the
  // timeout, so a late but good lock is never thrown away.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_inc_s = 1'b0;
    case (state_r)
      S_PLLRST: begin
        if (cnt_r == RST_LAST) begin
          state_nxt_s = S_WAITLOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      S_WAITLOCK: begin
        if (locked_sync_r) begin
          state_nxt_s = S_STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == LOCK_LAST) begin
          state_nxt_s = S_PLLRST;
          cnt_nxt_s   = CNT_ZERO;
          retry_inc_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      S_STABLE: begin
        // A dropout while settling is not a failed PLL. The controller waits
        // for lock again and does not re-reset the PLL.
        if (!locked_sync_r) begin
          state_nxt_s = S_WAITLOCK;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = S_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_nxt_s = CNT_ZERO;
        if (!locked_sync_r) begin
          state_nxt_s = S_PLLRST;
          retry_inc_s = 1'b1;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      default: begin
        state_nxt_s = S_PLLRST;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register, counter, retry counter and output flops. The outputs are
  // decoded from the next state, so each output pin comes straight from its
  // own flop with no logic after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_PLLRST;
      cnt_r       <= CNT_ZERO;
      retry_r     <= 4'd0;
      pll_rst_r   <= 1'b1;
      sys_reset_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      if (retry_inc_s) begin
        retry_r   <= sat_inc4(retry_r);
      end else begin
        retry_r   <= retry_r;
      end
      pll_rst_r   <= (state_nxt_s == S_PLLRST);
      sys_reset_r <= (state_nxt_s != S_RUN);
    end
  end

  assign pll_rst     = pll_rst_r;
  assign sys_reset   = sys_reset_r;
  assign retry_count = retry_r;
  assign state       = state_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Directed, self-checking bench for pll_reset_ctrl with RST_CYCLES=4,
// LOCK_TIMEOUT=32 and STABLE_CYCLES=8. Expected values are worked out by hand
// from edge counts. Inputs are driven, and outputs sampled, 1 time unit after
// each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_ctrl;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic [3:0] retry_count;
  logic [1:0] state;

  int total;
  int bad;

  pll_reset_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .retry_count(retry_count),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset, then release it just after an edge. The next edge is edge 1.
  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    step(2);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset pll_rst: got %0d expected 1", pll_rst); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL reset sys_reset: got %0d expected 1", sys_reset); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL reset retry_count: got %0d expected 0", retry_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset state: got %0d expected 0", state); end
  endtask

  task automatic test_timeout();
    pll_locked = 1'b0;
    reset = 1'b0;
    step(3);  // edge 3
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL timeout pll_rst_e3: got %0d expected 1", pll_rst); end
    step(1);  // edge 4
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL timeout pll_rst_e4: got %0d expected 0", pll_rst); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL timeout state_e4: got %0d expected 1", state); end
    step(31); // edge 35
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL timeout pll_rst_e35: got %0d expected 0", pll_rst); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL timeout retry_e35: got %0d expected 0", retry_count); end
    step(1);  // edge 36
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL timeout pll_rst_e36: got %0d expected 1", pll_rst); end
    total++; if (retry_count !== 4'd1) begin bad++; $display("FAIL timeout retry_e36: got %0d expected 1", retry_count); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL timeout sys_reset_e36: got %0d expected 1", sys_reset); end
    step(4);  // edge 40
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL timeout pll_rst_e40: got %0d expected 0", pll_rst); end
    step(32); // edge 72
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL timeout pll_rst_e72: got %0d expected 1", pll_rst); end
    total++; if (retry_count !== 4'd2) begin bad++; $display("FAIL timeout retry_e72: got %0d expected 2", retry_count); end
  endtask

  task automatic test_lock();
    pll_locked = 1'b0;
    apply_reset();
    step(4);  // now in S_WAITLOCK
    pll_locked = 1'b1;
    step(2);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL lock state_e2: got %0d expected 1", state); end
    step(1);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL lock state_e3: got %0d expected 2", state); end
    step(7);  // edge 10
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL lock sys_reset_e10: got %0d expected 1", sys_reset); end
    step(1);  // edge 11
    total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL lock sys_reset_e11: got %0d expected 0", sys_reset); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL lock state_e11: got %0d expected 3", state); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL lock pll_rst_e11: got %0d expected 0", pll_rst); end
  endtask

  task automatic test_run_loss();
    pll_locked = 1'b0;
    step(2);
    total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL run_loss sys_reset_e2: got %0d expected 0", sys_reset); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL run_loss state_e2: got %0d expected 3", state); end
    step(1);
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL run_loss sys_reset_e3: got %0d expected 1", sys_reset); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL run_loss pll_rst_e3: got %0d expected 1", pll_rst); end
    total++; if (retry_count !== 4'd1) begin bad++; $display("FAIL run_loss retry_e3: got %0d expected 1", retry_count); end
    step(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL run_loss pll_rst_e6: got %0d expected 1", pll_rst); end
    step(1);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL run_loss pll_rst_e7: got %0d expected 0", pll_rst); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL run_loss state_e7: got %0d expected 1", state); end
  endtask

  task automatic test_stable_glitch();
    pll_locked = 1'b1;
    step(3);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL glitch state_enter: got %0d expected 2", state); end
    step(2);
    pll_locked = 1'b0;
    step(2);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL glitch state_drop2: got %0d expected 2", state); end
    step(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL glitch state_drop3: got %0d expected 1", state); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL glitch pll_rst: got %0d expected 0", pll_rst); end
    total++; if (retry_count !== 4'd1) begin bad++; $display("FAIL glitch retry: got %0d expected 1", retry_count); end
    pll_locked = 1'b1;
    step(3);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL glitch state_relock: got %0d expected 2", state); end
    step(7);
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL glitch sys_reset_7: got %0d expected 1", sys_reset); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL glitch state_7: got %0d expected 2", state); end
    step(1);
    total++; if (sys_reset !== 1'b0) begin bad++; $display("FAIL glitch sys_reset_8: got %0d expected 0", sys_reset); end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL glitch state_8: got %0d expected 3", state); end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b1;
    #1;  // well before the next rising edge
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async pll_rst: got %0d expected 1", pll_rst); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL async sys_reset: got %0d expected 1", sys_reset); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL async retry: got %0d expected 0", retry_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL async state: got %0d expected 0", state); end
    step(1);
    reset = 1'b0;
    step(3);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL async restart_e3: got %0d expected 0", state); end
    step(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL async restart_e4: got %0d expected 1", state); end
  endtask

  task automatic test_lock_at_timeout();
    pll_locked = 1'b0;
    apply_reset();
    step(33); // edge 33
    pll_locked = 1'b1;
    step(2);  // edge 35
    total++; if (state !== 2'd1) begin bad++; $display("FAIL same_edge state_e35: got %0d expected 1", state); end
    step(1);  // edge 36: lock and timeout together
    total++; if (state !== 2'd2) begin bad++; $display("FAIL same_edge state_e36: got %0d expected 2", state); end
    total++; if (retry_count !== 4'd0) begin bad++; $display("FAIL same_edge retry: got %0d expected 0", retry_count); end
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL same_edge pll_rst: got %0d expected 0", pll_rst); end
  endtask

  task automatic test_retry_saturation();
    pll_locked = 1'b0;
    apply_reset();
    step(504); // 14th timeout
    total++; if (retry_count !== 4'd14) begin bad++; $display("FAIL sat retry_14: got %0d expected 14", retry_count); end
    step(36);  // 15th timeout
    total++; if (retry_count !== 4'd15) begin bad++; $display("FAIL sat retry_15: got %0d expected 15", retry_count); end
    step(180); // 20th timeout
    total++; if (retry_count !== 4'd15) begin bad++; $display("FAIL sat retry_20: got %0d expected 15", retry_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL sat state: got %0d expected 0", state); end
    total++; if (sys_reset !== 1'b1) begin bad++; $display("FAIL sat sys_reset: got %0d expected 1", sys_reset); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    pll_locked = 1'b0;
    test_reset();
    test_timeout();
    test_lock();
    test_run_loss();
    test_stable_glitch();
    test_async_reset();
    test_lock_at_timeout();
    test_retry_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
